// File: rtl/plab5_mcore_mem_net_mode_seq_if.sv
// Handshake bundle between the processor ports, MemNet and the mode sequencer.
// The master side drives the sequencer's inputs. The slave modport is the sequencer itself.
interface plab5_mcore_mem_net_mode_seq_if;
  logic mode_req_val, mode_req_target, mode_req_rdy, mode_done, mode, busy, cnt_err;
  logic proc_req_val_p0, proc_req_val_p1, proc_req_rdy_p0, proc_req_rdy_p1;
  logic net_req_val_p0, net_req_val_p1, net_req_rdy_p0, net_req_rdy_p1;
  logic resp_val_p0, resp_val_p1, resp_rdy_p0, resp_rdy_p1;

  modport master (
    output mode_req_val, mode_req_target,
    output proc_req_val_p0, proc_req_val_p1, net_req_rdy_p0, net_req_rdy_p1,
    output resp_val_p0, resp_val_p1, resp_rdy_p0, resp_rdy_p1,
    input  mode_req_rdy, mode_done, mode, busy, cnt_err,
    input  proc_req_rdy_p0, proc_req_rdy_p1, net_req_val_p0, net_req_val_p1
  );

  modport slave (
    input  mode_req_val, mode_req_target,
    input  proc_req_val_p0, proc_req_val_p1, net_req_rdy_p0, net_req_rdy_p1,
    input  resp_val_p0, resp_val_p1, resp_rdy_p0, resp_rdy_p1,
    output mode_req_rdy, mode_done, mode, busy, cnt_err,
    output proc_req_rdy_p0, proc_req_rdy_p1, net_req_val_p0, net_req_val_p1
  );
endinterface

// File: rtl/plab5_mcore_mem_net_mode_seq.sv
// MemNet mode sequencer: closes the request gates, drains in-flight traffic, flips the mode,
// then holds the gates closed for a settle window before reopening.
module mode_seq_port #(
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_open_i,
  input  logic proc_req_val_i,
  input  logic net_req_rdy_i,
  input  logic resp_val_i,
  input  logic resp_rdy_i,
  output logic proc_req_rdy_o,
  output logic net_req_val_o,
  output logic cnt_zero_o,
  output logic underflow_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic full, inc, dec;

  assign full           = &cnt_q;
  assign net_req_val_o  = gate_open_i && proc_req_val_i && !full;
  assign proc_req_rdy_o = gate_open_i && net_req_rdy_i && !full;
  assign inc            = net_req_val_o && net_req_rdy_i;
  assign dec            = resp_val_i && resp_rdy_i;
  assign cnt_zero_o     = (cnt_q == '0);
  // A lone response with nothing outstanding is a protocol error; the count saturates at 0.
  assign underflow_o    = dec && !inc && cnt_zero_o;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec)                     cnt_d = cnt_q + CNT_W'(1);
    else if (dec && !inc && !cnt_zero_o) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

module plab5_mcore_mem_net_mode_seq #(
  parameter int p_cnt_nbits     = 4,
  parameter int p_settle_cycles = 2,
  parameter int p_reset_mode    = 0
) (
  input logic clk,
  input logic reset,
  plab5_mcore_mem_net_mode_seq_if.slave bus
);
  localparam int NPORT = 2;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;
  localparam logic [3:0] SETTLE_INIT = 4'(p_settle_cycles);
  localparam logic       RST_MODE    = 1'(p_reset_mode);

  logic [1:0] state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic       mode_q, mode_d, tgt_q, tgt_d, done_q, done_d, err_q, err_d;
  logic       gate_open;

  logic [NPORT-1:0] pv, nr, rv, rr, prdy, nval, zero, uflow;

  assign pv = {bus.proc_req_val_p1, bus.proc_req_val_p0};
  assign nr = {bus.net_req_rdy_p1,  bus.net_req_rdy_p0};
  assign rv = {bus.resp_val_p1,     bus.resp_val_p0};
  assign rr = {bus.resp_rdy_p1,     bus.resp_rdy_p0};

  assign gate_open = (state_q == IDLE);

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    mode_seq_port #(.CNT_W(p_cnt_nbits)) u_port (
      .clk            (clk),
      .reset          (reset),
      .gate_open_i    (gate_open),
      .proc_req_val_i (pv[g]),
      .net_req_rdy_i  (nr[g]),
      .resp_val_i     (rv[g]),
      .resp_rdy_i     (rr[g]),
      .proc_req_rdy_o (prdy[g]),
      .net_req_val_o  (nval[g]),
      .cnt_zero_o     (zero[g]),
      .underflow_o    (uflow[g])
    );
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    tgt_d    = tgt_q;
    done_d   = 1'b0;
    err_d    = err_q | (|uflow);
    case (state_q)
      IDLE: begin
        if (bus.mode_req_val) begin
          if (bus.mode_req_target == mode_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d   = bus.mode_req_target;
            state_d = DRAIN;
          end
        end
      end
      // Counts are registered, so requests fired in the accept cycle are seen here.
      DRAIN:  if (&zero) state_d = SWITCH;
      SWITCH: begin
        mode_d   = tgt_q;
        settle_d = SETTLE_INIT;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      mode_q   <= RST_MODE;
      tgt_q    <= RST_MODE;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      tgt_q    <= tgt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.mode_req_rdy    = gate_open;
  assign bus.busy            = !gate_open;
  assign bus.mode            = mode_q;
  assign bus.mode_done       = done_q;
  assign bus.cnt_err         = err_q;
  assign bus.proc_req_rdy_p0 = prdy[0];
  assign bus.proc_req_rdy_p1 = prdy[1];
  assign bus.net_req_val_p0  = nval[0];
  assign bus.net_req_val_p1  = nval[1];
endmodule

// File: tb/tb_plab5_mcore_mem_net_mode_seq.sv
// Bench for the MemNet mode sequencer: directed vector table, reset-mid-drain sequence,
// then randomized traffic against a timeline-based reference model.
module tb_plab5_mcore_mem_net_mode_seq;
  localparam int CNT_NBITS = 2;
  localparam int SETTLE    = 2;
  localparam int CNT_MAX   = (1 << CNT_NBITS) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  plab5_mcore_mem_net_mode_seq_if bus();

  plab5_mcore_mem_net_mode_seq #(
    .p_cnt_nbits(CNT_NBITS), .p_settle_cycles(SETTLE), .p_reset_mode(0)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  // Stimulus for one cycle.
  bit mrv, mtgt;
  bit [1:0] pv, nr, rv, rr;

  int vectors = 0;
  int miscompares = 0;

  // Expected output word: {mode_req_rdy, mode_done, mode, busy, cnt_err, proc_req_rdy[1:0], net_req_val[1:0]}
  typedef struct {
    bit mrv, mtgt;
    bit [1:0] pv, nr, rv, rr;
    logic [8:0] exp;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit a, input bit b, input bit [1:0] p, input bit [1:0] n,
                     input bit [1:0] r, input bit [1:0] q, input logic [8:0] e);
    vec_t v;
    v.mrv = a; v.mtgt = b; v.pv = p; v.nr = n; v.rv = r; v.rr = q; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic drive();
    bus.mode_req_val    = mrv;
    bus.mode_req_target = mtgt;
    bus.proc_req_val_p0 = pv[0]; bus.proc_req_val_p1 = pv[1];
    bus.net_req_rdy_p0  = nr[0]; bus.net_req_rdy_p1  = nr[1];
    bus.resp_val_p0     = rv[0]; bus.resp_val_p1     = rv[1];
    bus.resp_rdy_p0     = rr[0]; bus.resp_rdy_p1     = rr[1];
  endtask

  task automatic clear_inputs();
    mrv = 0; mtgt = 0; pv = 0; nr = 0; rv = 0; rr = 0;
    drive();
  endtask

  function automatic logic [8:0] actual();
    return {bus.mode_req_rdy, bus.mode_done, bus.mode, bus.busy, bus.cnt_err,
            bus.proc_req_rdy_p1, bus.proc_req_rdy_p0, bus.net_req_val_p1, bus.net_req_val_p0};
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = actual();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b want %b (rdy,done,mode,busy,err,prdy1,prdy0,nval1,nval0)",
               name, act, exp);
    end
  endtask

  // Reference model: counts, a drain flag and absolute cycle numbers at which the mode
  // flips and the sequencer is idle again.
  int  m_cnt[2];
  bit  m_err, m_mode, m_done, m_drain, m_tgt;
  int  m_flip_at, m_idle_at, cyc;

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_err = 0; m_mode = 0; m_done = 0; m_drain = 0; m_tgt = 0;
    m_flip_at = -1; m_idle_at = -1; cyc = 0;
  endtask

  function automatic bit m_busy();
    return m_drain || (m_idle_at > cyc);
  endfunction

  function automatic logic [8:0] model_exp();
    bit open;
    bit [1:0] prdy, nval;
    open = !m_busy();
    for (int p = 0; p < 2; p++) begin
      prdy[p] = open && nr[p] && (m_cnt[p] < CNT_MAX);
      nval[p] = open && pv[p] && (m_cnt[p] < CNT_MAX);
    end
    return {open, m_done, m_mode, !open, m_err, prdy, nval};
  endfunction

  task automatic model_edge();
    bit b, nd, zero;
    logic [8:0] e;
    e = model_exp();
    b = m_busy();
    nd = 0;
    zero = (m_cnt[0] == 0) && (m_cnt[1] == 0);
    if (!b && mrv) begin
      if (mtgt == m_mode) nd = 1;
      else begin m_drain = 1; m_tgt = mtgt; end
    end else if (m_drain && zero) begin
      m_drain   = 0;
      m_flip_at = cyc + 2;
      m_idle_at = cyc + 3 + SETTLE;
    end
    for (int p = 0; p < 2; p++) begin
      bit inc, dec;
      inc = e[p] && nr[p];
      dec = rv[p] && rr[p];
      if (inc && !dec) m_cnt[p]++;
      else if (dec && !inc) begin
        if (m_cnt[p] == 0) m_err = 1;
        else m_cnt[p]--;
      end
    end
    cyc++;
    if (cyc == m_flip_at) m_mode = m_tgt;
    if (cyc == m_idle_at) nd = 1;
    m_done = nd;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", model_exp());
    reset = 1'b1;

    // Directed table, counter limit 3, settle 2, starting from reset.
    add(0,0,2'b01,2'b01,2'b00,2'b00,9'b10000_01_01);
    add(0,0,2'b01,2'b01,2'b00,2'b00,9'b10000_01_01);
    add(0,0,2'b01,2'b01,2'b00,2'b00,9'b10000_01_01);
    add(0,0,2'b01,2'b01,2'b00,2'b00,9'b10000_00_00); // full at 3
    add(0,0,2'b01,2'b01,2'b01,2'b01,9'b10000_00_00); // resp only -> 2
    add(0,0,2'b01,2'b01,2'b01,2'b01,9'b10000_01_01); // req+resp -> stays 2
    add(0,0,2'b01,2'b01,2'b00,2'b00,9'b10000_01_01); // -> 3
    add(0,0,2'b01,2'b01,2'b00,2'b00,9'b10000_00_00);
    add(1,1,2'b00,2'b00,2'b00,2'b00,9'b10000_00_00); // accept mode change
    add(0,0,2'b11,2'b11,2'b00,2'b00,9'b00010_00_00); // drain, gated
    add(0,0,2'b11,2'b11,2'b01,2'b01,9'b00010_00_00);
    add(0,0,2'b11,2'b11,2'b01,2'b01,9'b00010_00_00);
    add(0,0,2'b11,2'b11,2'b01,2'b01,9'b00010_00_00); // -> 0
    add(0,0,2'b11,2'b11,2'b00,2'b00,9'b00010_00_00); // drain sees empty
    add(1,0,2'b00,2'b00,2'b00,2'b00,9'b00010_00_00); // switch; busy ignores request
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b00110_00_00); // settle, mode flipped
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b00110_00_00);
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b00110_00_00);
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b11100_00_00); // idle + done
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b10100_00_00);
    add(1,1,2'b00,2'b00,2'b00,2'b00,9'b10100_00_00); // same-mode request
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b11100_00_00);
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b10100_00_00);
    add(0,0,2'b00,2'b00,2'b10,2'b10,9'b10100_00_00); // resp at count 0
    add(0,0,2'b00,2'b00,2'b00,2'b00,9'b10101_00_00);
    add(0,0,2'b10,2'b10,2'b00,2'b00,9'b10101_10_10);
    add(0,0,2'b00,2'b00,2'b10,2'b10,9'b10101_00_00); // err sticky
    foreach (tv[i]) begin
      mrv = tv[i].mrv; mtgt = tv[i].mtgt; pv = tv[i].pv; nr = tv[i].nr;
      rv = tv[i].rv; rr = tv[i].rr;
      drive();
      @(negedge clk);
      check($sformatf("table[%0d]", i), tv[i].exp);
      @(posedge clk); #1;
    end

    // Reset abandons a change in progress.
    mrv = 1; mtgt = 0; pv = 2'b01; nr = 2'b01; rv = 0; rr = 0; drive();
    @(negedge clk);
    check("accept_with_fire", 9'b10101_01_01);
    @(posedge clk); #1;
    mrv = 0; pv = 2'b11; nr = 2'b11; drive();
    @(negedge clk);
    check("drain_gated", 9'b00111_00_00);
    reset = 1'b0;
    pv = 0; nr = 0; drive();
    #1;
    check("async_reset", 9'b10000_00_00);
    @(posedge clk); #1;
    check("reset_held", 9'b10000_00_00);
    reset = 1'b1;
    @(negedge clk);
    check("reset_release", 9'b10000_00_00);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        check("rand_reset", model_exp());
        @(posedge clk); #1;
        reset = 1'b1;
        continue;
      end
      mrv  = ($urandom_range(0, 7) == 0);
      mtgt = 1'($urandom);
      pv   = 2'($urandom);
      nr   = 2'($urandom);
      rr   = 2'($urandom);
      for (int p = 0; p < 2; p++)
        rv[p] = (m_cnt[p] > 0) ? 1'($urandom) : ($urandom_range(0, 63) == 0);
      drive();
      @(negedge clk);
      check($sformatf("rand[%0d]", n), model_exp());
      model_edge();
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
